// File: rtl/usb4_ll_pkg.sv
// Shared logical-layer types for the receive-side deskew/merge path.
// Holds the deskew state encoding and the default lane symbol width.
package usb4_ll_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_ALIGNED
    } state_e;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane synchronous FIFO with flush; head is visible combinationally on rd_data_o.
// One-cycle write-to-visible latency; a write to a full FIFO is accepted only alongside a read.
module lane_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_wr;
    logic              do_rd;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/lane_deskew_merge.sv
// Deskews NUM_LANES receive lanes on their alignment markers and merges them round-robin.
// Input-to-output latency >= 2 cycles; output holds under !ready_i, overflow/excess skew pulse skew_error_o.
module lane_deskew_merge import usb4_ll_pkg::*; #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 8,
    parameter int MAX_SKEW  = 6,
    localparam int SKW      = $clog2(MAX_SKEW + 1)
) (
    input  logic                          fsm_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_LANES-1:0]          lane_valid_i,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_data_i,
    input  logic [NUM_LANES-1:0]          lane_align_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          aligned_o,
    output logic [SKW-1:0]                skew_o,
    output logic                          skew_error_o
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_e                state_q, state_d;
    logic [NUM_LANES-1:0]  seen_q, seen_d;
    logic [SKW-1:0]        cnt_q, cnt_d;
    logic [SKW-1:0]        skew_q, skew_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [PW-1:0]         p_q, p_d;

    logic                  flush;
    logic [NUM_LANES-1:0]  wr_en;
    logic [NUM_LANES-1:0]  rd_en;
    logic [NUM_LANES-1:0]  fifo_full;
    logic [NUM_LANES-1:0]  fifo_empty;
    logic [DATA_W-1:0]     fifo_rdata [NUM_LANES];
    logic [CW-1:0]         unused_count [NUM_LANES];
    logic [NUM_LANES-1:0]  marker;
    logic [NUM_LANES-1:0]  payload;
    logic [NUM_LANES-1:0]  seen_nx;
    logic [SKW-1:0]        cur_skew;

    assign marker   = lane_valid_i & lane_align_i;
    assign payload  = lane_valid_i & ~lane_align_i;
    assign seen_nx  = seen_q | marker;
    assign cur_skew = (|seen_q) ? cnt_q : '0;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        lane_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
            .clk       (fsm_clk),
            .rst       (rst),
            .flush_i   (flush),
            .wr_en_i   (wr_en[n]),
            .wr_data_i (lane_data_i[n*DATA_W +: DATA_W]),
            .rd_en_i   (rd_en[n]),
            .rd_data_o (fifo_rdata[n]),
            .full_o    (fifo_full[n]),
            .empty_o   (fifo_empty[n]),
            .count_o   (unused_count[n])
        );
    end

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        err_d   = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        p_d     = p_q;
        flush   = 1'b0;
        wr_en   = '0;
        rd_en   = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                // Only lanes already past their marker buffer data; the marker itself is dropped.
                wr_en  = payload & seen_q;
                seen_d = seen_nx;
                if (&seen_nx) begin
                    skew_d  = cur_skew;
                    cnt_d   = '0;
                    state_d = ST_ALIGNED;
                end else if (|seen_nx) begin
                    if (cur_skew == SKW'(MAX_SKEW)) begin
                        err_d  = 1'b1;
                        flush  = 1'b1;
                        seen_d = '0;
                    end else begin
                        cnt_d = cur_skew + SKW'(1);
                    end
                end
            end
            ST_ALIGNED: begin
                wr_en = payload;
                if (!fifo_empty[p_q] && (!valid_q || ready_i)) begin
                    rd_en[p_q] = 1'b1;
                    valid_d    = 1'b1;
                    data_d     = fifo_rdata[p_q];
                    p_d        = (p_q == PW'(NUM_LANES - 1)) ? '0 : p_q + PW'(1);
                end else if (ready_i) begin
                    valid_d = 1'b0;
                end
                if (|(wr_en & fifo_full & ~rd_en)) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    seen_d  = '0;
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            seen_d  = '0;
            err_d   = 1'b0;
            flush   = 1'b1;
        end

        if (flush) begin
            valid_d = 1'b0;
            p_d     = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge fsm_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seen_q  <= '0;
            cnt_q   <= '0;
            skew_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            p_q     <= p_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign aligned_o    = (state_q == ST_ALIGNED);
    assign skew_o       = skew_q;
    assign skew_error_o = err_q;

endmodule

// File: tb/tb_lane_deskew_merge.sv
// Bench for lane_deskew_merge: directed vector table on a 2-lane instance,
// hand-written reset sequence, and randomized 4-lane rounds against a round-robin model.
module tb_lane_deskew_merge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en2, rdy2, vld2, alg2, err2;
    logic [1:0]  v2, a2;
    logic [15:0] d2;
    logic [7:0]  dat2;
    logic [2:0]  skw2;

    logic        en4, rdy4, vld4, alg4, err4;
    logic [3:0]  v4, a4;
    logic [31:0] d4;
    logic [7:0]  dat4;
    logic [2:0]  skw4;

    lane_deskew_merge #(.NUM_LANES(2), .DATA_W(8), .DEPTH(8), .MAX_SKEW(6)) u2 (
        .fsm_clk(clk), .rst(rst), .enable(en2),
        .lane_valid_i(v2), .lane_data_i(d2), .lane_align_i(a2),
        .data_o(dat2), .valid_o(vld2), .ready_i(rdy2),
        .aligned_o(alg2), .skew_o(skw2), .skew_error_o(err2)
    );

    lane_deskew_merge #(.NUM_LANES(4), .DATA_W(8), .DEPTH(8), .MAX_SKEW(6)) u4 (
        .fsm_clk(clk), .rst(rst), .enable(en4),
        .lane_valid_i(v4), .lane_data_i(d4), .lane_align_i(a4),
        .data_o(dat4), .valid_o(vld4), .ready_i(rdy4),
        .aligned_o(alg4), .skew_o(skw4), .skew_error_o(err4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic [1:0] v;
        logic [1:0] a;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eal;
        logic       eerr;
        logic [2:0] esk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic [1:0] v, input logic [1:0] a,
                       input logic [7:0] d0, input logic [7:0] d1, input logic rdy,
                       input logic ev, input logic [7:0] ed, input logic eal,
                       input logic eerr, input logic [2:0] esk);
        vec_t r;
        r.en = en; r.v = v; r.a = a; r.d0 = d0; r.d1 = d1; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.eal = eal; r.eerr = eerr; r.esk = esk;
        tbl.push_back(r);
    endtask

    logic [7:0] lb [4][8];
    int         off [4];
    int         sent [4];
    logic [7:0] got [$];
    logic       saw_err;
    int         mn, mx;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en2 = 0; rdy2 = 0; v2 = 0; a2 = 0; d2 = 0;
        en4 = 0; rdy4 = 0; v4 = 0; a4 = 0; d4 = 0;

        // Zero skew: both markers together, then interleaved payload.
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        add(1, 2'b11, 2'b11, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0, 0);
        add(1, 2'b11, 2'b00, 8'h10, 8'h11, 1, 0, 8'h00, 1, 0, 0);
        add(1, 2'b11, 2'b00, 8'h12, 8'h13, 1, 1, 8'h10, 1, 0, 0);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h11, 1, 0, 0);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h12, 1, 0, 0);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h13, 1, 0, 0);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0, 0);
        add(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        // Skew 3: lane0 bytes buffered before lane1 marker; unseen lane1 junk dropped.
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        add(1, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        add(1, 2'b11, 2'b00, 8'h20, 8'hEE, 1, 0, 8'h00, 0, 0, 0);
        add(1, 2'b01, 2'b00, 8'h22, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        add(1, 2'b10, 2'b10, 8'h00, 8'hBB, 1, 0, 8'h00, 1, 0, 3);
        add(1, 2'b10, 2'b00, 8'h00, 8'h21, 1, 1, 8'h20, 1, 0, 3);
        add(1, 2'b10, 2'b00, 8'h00, 8'h23, 1, 1, 8'h21, 1, 0, 3);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h22, 1, 0, 3);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h23, 1, 0, 3);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0, 3);
        add(1, 2'b11, 2'b00, 8'h30, 8'h31, 1, 0, 8'h00, 1, 0, 3);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 8'h30, 1, 0, 3);
        // Enable dropped mid-stream.
        add(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 3);
        // Excessive skew: lane1 marker absent for MAX_SKEW cycles.
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 3);
        add(1, 2'b01, 2'b01, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 3);
        for (int k = 0; k < 5; k++) add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 3);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 3);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 3);
        add(1, 2'b10, 2'b10, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 3);
        add(1, 2'b01, 2'b01, 8'h00, 8'h00, 1, 0, 8'h00, 1, 0, 1);
        // Backpressure and overflow on lane0.
        add(1, 2'b01, 2'b00, 8'h3F, 8'h00, 0, 0, 8'h00, 1, 0, 1);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 1, 8'h3F, 1, 0, 1);
        for (int k = 0; k < 8; k++) add(1, 2'b01, 2'b00, 8'(8'h40 + k), 8'h00, 0, 1, 8'h3F, 1, 0, 1);
        add(1, 2'b01, 2'b00, 8'h48, 8'h00, 0, 0, 8'h00, 0, 1, 1);
        add(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1);

        #12;
        chk("reset u2 valid", vld2, 0);
        chk("reset u2 data", dat2, 0);
        chk("reset u2 aligned", alg2, 0);
        chk("reset u2 skew", skw2, 0);
        chk("reset u2 err", err2, 0);
        chk("reset u4 valid", vld4, 0);
        chk("reset u4 aligned", alg4, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            en2 = tbl[i].en; v2 = tbl[i].v; a2 = tbl[i].a;
            d2 = {tbl[i].d1, tbl[i].d0}; rdy2 = tbl[i].rdy;
            step();
            chk($sformatf("row%0d valid", i), vld2, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("row%0d data", i), dat2, tbl[i].ed);
            chk($sformatf("row%0d aligned", i), alg2, tbl[i].eal);
            chk($sformatf("row%0d err", i), err2, tbl[i].eerr);
            chk($sformatf("row%0d skew", i), skw2, tbl[i].esk);
        end

        // Asynchronous reset mid-transfer.
        v2 = 2'b01; a2 = 2'b01; rdy2 = 1'b0; step();
        v2 = 2'b10; a2 = 2'b10; step();
        v2 = 2'b11; a2 = 2'b00; d2 = 16'h5150; step();
        v2 = 2'b00; step();
        chk("pre-reset valid", vld2, 1);
        chk("pre-reset data", dat2, 8'h50);
        chk("pre-reset skew", skw2, 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset valid", vld2, 0);
        chk("async reset data", dat2, 0);
        chk("async reset aligned", alg2, 0);
        chk("async reset skew", skw2, 0);
        chk("async reset err", err2, 0);
        #2 rst = 1'b0;
        rdy2 = 1'b1;
        step(); step(); step();
        chk("post-reset valid", vld2, 0);
        chk("post-reset aligned", alg2, 0);
        en2 = 1'b0;

        // Randomized 4-lane rounds.
        for (int r = 0; r < 20; r++) begin
            en4 = 0; v4 = 0; a4 = 0; rdy4 = 1;
            step();
            en4 = 1;
            step();
            got.delete();
            saw_err = 1'b0;
            mn = 99; mx = -1;
            for (int n = 0; n < 4; n++) begin
                off[n] = $urandom_range(0, 5);
                sent[n] = 0;
                if (off[n] < mn) mn = off[n];
                if (off[n] > mx) mx = off[n];
                for (int i = 0; i < 8; i++) lb[n][i] = 8'($urandom);
            end
            for (int t = 0; t < 300 && got.size() < 32; t++) begin
                v4 = 0; a4 = 0;
                for (int n = 0; n < 4; n++) begin
                    if (t == off[n]) begin
                        v4[n] = 1'b1; a4[n] = 1'b1; d4[n*8 +: 8] = 8'($urandom);
                    end else if (t > off[n] && sent[n] < 8 && $urandom_range(0, 3) != 0) begin
                        v4[n] = 1'b1; d4[n*8 +: 8] = lb[n][sent[n]];
                        sent[n]++;
                    end else if (t < off[n] && $urandom_range(0, 1) == 1) begin
                        v4[n] = 1'b1; d4[n*8 +: 8] = 8'($urandom);
                    end
                end
                rdy4 = ($urandom_range(0, 3) != 0);
                if (vld4 && rdy4) got.push_back(dat4);
                step();
                if (err4) saw_err = 1'b1;
            end
            chk($sformatf("rnd%0d count", r), got.size(), 32);
            chk($sformatf("rnd%0d no error", r), saw_err, 0);
            chk($sformatf("rnd%0d skew", r), skw4, mx - mn);
            chk($sformatf("rnd%0d aligned", r), alg4, 1);
            for (int i = 0; i < got.size() && i < 32; i++)
                chk($sformatf("rnd%0d byte%0d", r, i), got[i], lb[i % 4][i / 4]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
